key_matrix_scan: RTL

- Scans a 4x4 push-button matrix, the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column low at a time, samples the active-low row lines, and builds a 16-key frame.
- Debounces the frame result across whole frames and reports each accepted key press once.
- Sits beside the clock controller so digit and alarm entry can come from a keypad instead of single switches.

---
 rtl/key_matrix_scan_if.sv | 19 +
 rtl/key_matrix_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if: keypad matrix strobes/returns plus accepted-key outputs
interface key_matrix_scan_if;
    logic [3:0] o_col;
    logic [3:0] i_row;
    logic [3:0] o_key_code;
    logic       o_key_valid;
    logic       o_key_held;
    logic       o_multi;

    modport master (
        output o_col, o_key_code, o_key_valid, o_key_held, o_multi,
        input  i_row
    );

    modport slave (
        input  o_col, o_key_code, o_key_valid, o_key_held, o_multi,
        output i_row
    );
endinterface

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 keypad scanner with whole-frame debounce and one-shot key reporting
module key_matrix_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    key_matrix_scan_if.master kbd
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [1:0] C_NONE   = 2'd0;
    localparam logic [1:0] C_SINGLE = 2'd1;
    localparam logic [1:0] C_MULTI  = 2'd2;

    typedef enum logic [1:0] {S_REL, S_PRESS, S_MULTI, S_LOCK} state_t;

    logic [DW-1:0] r_div;
    logic          w_tick;
    logic [3:0]    r_sync1, r_sync2;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col;
    logic [15:0]   r_frame, w_frame_nx;
    logic          w_done;
    logic [4:0]    w_ones;
    logic [3:0]    w_k, w_k_eff;
    logic [1:0]    w_class;
    logic [1:0]    r_prev_class;
    logic [3:0]    r_prev_k;
    logic [3:0]    r_cnt, w_cnt_nx;
    logic          w_same, w_evt;
    state_t        r_state, w_state_nx;
    logic [3:0]    r_code, w_code_nx;
    logic          r_valid, w_valid_nx;
    logic          r_held, w_held_nx;
    logic          r_multi, w_multi_nx;

    assign w_tick = r_div == DW'(SCAN_DIV - 1);
    assign w_done = w_tick && r_col_idx == 2'd3;

    // column dwell divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_div <= '0;
        else     r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    // two-flop synchronizer on the asynchronous row returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= kbd.i_row;
            r_sync2 <= r_sync1;
        end
    end

    // frame image with the current column's end-of-dwell sample merged in
    always_comb begin
        w_frame_nx = r_frame;
        for (int r = 0; r < 4; r++) w_frame_nx[{2'(r), r_col_idx}] = ~r_sync2[r];
    end

    // capture column sample and rotate the one-cold strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame   <= '0;
            r_col_idx <= '0;
            r_col     <= 4'b1110;
        end else if (w_tick) begin
            r_frame   <= w_frame_nx;
            r_col_idx <= r_col_idx + 1'b1;
            r_col     <= {r_col[2:0], r_col[3]};
        end
    end

    // classify the completed frame as none / single key / multiple keys
    always_comb begin
        w_ones = '0;
        w_k    = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_nx[i]) begin
                w_ones = w_ones + 5'd1;
                w_k    = 4'(i);
            end
        end
    end

    assign w_class  = (w_ones == 5'd0) ? C_NONE : (w_ones == 5'd1) ? C_SINGLE : C_MULTI;
    assign w_k_eff  = (w_class == C_SINGLE) ? w_k : 4'd0;
    assign w_same   = {w_class, w_k_eff} == {r_prev_class, r_prev_k};
    assign w_cnt_nx = !w_same ? 4'd1 : (r_cnt == 4'(DEB_SCANS)) ? r_cnt : r_cnt + 4'd1;
    assign w_evt    = w_done && w_same && r_cnt == 4'(DEB_SCANS - 1);

    // frame-to-frame stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_class <= C_NONE;
            r_prev_k     <= '0;
            r_cnt        <= '0;
        end else if (w_done) begin
            r_prev_class <= w_class;
            r_prev_k     <= w_k_eff;
            r_cnt        <= w_cnt_nx;
        end
    end

    // key acceptance FSM, stepped only by stable-frame events
    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        w_held_nx  = r_held;
        w_multi_nx = r_multi;
        if (w_evt) begin
            case (r_state)
                S_REL: begin
                    if (w_class == C_SINGLE) begin
                        w_state_nx = S_PRESS;
                        w_code_nx  = w_k;
                        w_valid_nx = 1'b1;
                        w_held_nx  = 1'b1;
                    end else if (w_class == C_MULTI) begin
                        w_state_nx = S_MULTI;
                        w_multi_nx = 1'b1;
                    end
                end
                S_PRESS: begin
                    if (w_class == C_NONE) begin
                        w_state_nx = S_REL;
                        w_held_nx  = 1'b0;
                    end else if (w_class == C_MULTI) begin
                        w_state_nx = S_MULTI;
                        w_held_nx  = 1'b0;
                        w_multi_nx = 1'b1;
                    end else if (w_k != r_code) begin
                        w_state_nx = S_LOCK;
                        w_held_nx  = 1'b0;
                    end
                end
                S_MULTI: begin
                    if (w_class == C_NONE) begin
                        w_state_nx = S_REL;
                        w_multi_nx = 1'b0;
                    end
                end
                S_LOCK: begin
                    if (w_class == C_NONE) w_state_nx = S_REL;
                    else if (w_class == C_MULTI) begin
                        w_state_nx = S_MULTI;
                        w_multi_nx = 1'b1;
                    end
                end
                default: w_state_nx = S_REL;
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REL;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_held  <= w_held_nx;
            r_multi <= w_multi_nx;
        end
    end

    assign kbd.o_col       = r_col;
    assign kbd.o_key_code  = r_code;
    assign kbd.o_key_valid = r_valid;
    assign kbd.o_key_held  = r_held;
    assign kbd.o_multi     = r_multi;
endmodule
